// File: rtl/axis_traffic_gen_pkg.sv
// Shared definitions for the AXI-Stream traffic generator: default widths,
// the AXI-Lite register map, CONTROL command codes, FSM states and the beat
// pattern helper.
package axis_traffic_gen_pkg;

    // Default stream beat width and control word width, both in bytes
    localparam int DATA_WIDTH       = 8;
    localparam int STORE_DATA_WIDTH = 4;

    // Register byte offsets
    localparam logic [15:0] REG_CONTROL  = 16'h0010;
    localparam logic [15:0] REG_BEATS_LO = 16'h0014;
    localparam logic [15:0] REG_BEATS_HI = 16'h0018;
    localparam logic [15:0] REG_GAP      = 16'h001C;
    localparam logic [15:0] REG_MODE     = 16'h0020;
    localparam logic [15:0] REG_SEED     = 16'h0024;
    localparam logic [15:0] REG_SENT_LO  = 16'h0028;
    localparam logic [15:0] REG_SENT_HI  = 16'h002C;
    localparam logic [15:0] REG_STATUS   = 16'h0030;

    // CONTROL command codes
    localparam logic [31:0] CTRL_STOP  = 32'd0;
    localparam logic [31:0] CTRL_START = 32'd1;
    localparam logic [31:0] CTRL_CLEAR = 32'd2;

    localparam logic [31:0] UNMAPPED_RDATA = 32'h1234_dead;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2,
        ST_DONE = 2'd3
    } gen_state_e;

    // One 32-bit lane of a beat: constant seed, or seed plus the beat index
    function automatic logic [31:0] lane_value(input logic [31:0] seed,
                                               input logic        mode,
                                               input logic [31:0] idx);
        return mode ? seed : seed + idx;
    endfunction

endpackage

// File: rtl/axis_traffic_gen_if.sv
// Bus bundles for the traffic generator: the AXI-Lite control slave port and
// the generated AXI-Stream output.

interface axil_ctrl_if;
    logic        awvalid;
    logic        awready;
    logic [15:0] awaddr;
    logic        wvalid;
    logic        wready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        bvalid;
    logic        bready;
    logic [1:0]  bresp;
    logic        arvalid;
    logic        arready;
    logic [15:0] araddr;
    logic        rvalid;
    logic        rready;
    logic [31:0] rdata;
    logic [1:0]  rresp;

    modport slave (
        input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport master (
        output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
endinterface

interface axis_stream_if
    import axis_traffic_gen_pkg::*;
#(
    parameter int DATA_BYTES = DATA_WIDTH
);
    logic [DATA_BYTES*8-1:0] tdata;
    logic                    tvalid;
    logic                    tready;

    modport master (output tdata, tvalid, input tready);
    modport slave  (input tdata, tvalid, output tready);
endinterface

// File: rtl/axis_traffic_gen_regs.sv
// AXI-Lite register file for the traffic generator. Holds the configuration
// registers, emits a one-cycle clear pulse when CONTROL is written with the
// clear code, and returns the live SENT counter and STATUS on reads.
module axis_gen_regs
    import axis_traffic_gen_pkg::*;
(
    input  logic         ap_clk,
    input  logic         ap_rst_n,
    axil_ctrl_if.slave   s_axi_control,
    input  logic [63:0]  sent_i,
    input  logic         busy_i,
    input  logic         done_i,
    output logic [31:0]  control_o,
    output logic [63:0]  beats_o,
    output logic [15:0]  gap_o,
    output logic         mode_o,
    output logic [31:0]  seed_o,
    output logic         clear_o
);

    logic [15:0] awaddr_q,  awaddr_d;
    logic [31:0] control_q, control_d;
    logic [63:0] beats_q,   beats_d;
    logic [15:0] gap_q,     gap_d;
    logic        mode_q,    mode_d;
    logic [31:0] seed_q,    seed_d;
    logic        clear_q,   clear_d;
    logic        bvalid_q,  bvalid_d;
    logic        rvalid_q,  rvalid_d;
    logic [31:0] rdata_q,   rdata_d;
    logic [31:0] rd_val;
    logic [15:0] waddr;
    logic        unused_wstrb;

    // Byte enables are not honoured; every write replaces the full word
    assign unused_wstrb = ^s_axi_control.wstrb;

    // A W beat uses the address presented alongside it, else the last latched one
    assign waddr = s_axi_control.awvalid ? s_axi_control.awaddr : awaddr_q;

    assign s_axi_control.awready = 1'b1;
    assign s_axi_control.wready  = 1'b1;
    assign s_axi_control.bvalid  = bvalid_q;
    assign s_axi_control.bresp   = 2'b00;
    assign s_axi_control.arready = !rvalid_q;
    assign s_axi_control.rvalid  = rvalid_q;
    assign s_axi_control.rdata   = rdata_q;
    assign s_axi_control.rresp   = 2'b00;

    assign control_o = control_q;
    assign beats_o   = beats_q;
    assign gap_o     = gap_q;
    assign mode_o    = mode_q;
    assign seed_o    = seed_q;
    assign clear_o   = clear_q;

    // Write channel: address latch, register updates and write response
    always_comb begin
        awaddr_d  = s_axi_control.awvalid ? s_axi_control.awaddr : awaddr_q;
        control_d = control_q;
        beats_d   = beats_q;
        gap_d     = gap_q;
        mode_d    = mode_q;
        seed_d    = seed_q;
        clear_d   = 1'b0;
        bvalid_d  = bvalid_q && !s_axi_control.bready;
        if (s_axi_control.wvalid) begin
            bvalid_d = 1'b1;
            case (waddr)
                REG_CONTROL: begin
                    control_d = s_axi_control.wdata;
                    clear_d   = (s_axi_control.wdata == CTRL_CLEAR);
                end
                REG_BEATS_LO: beats_d[31:0]  = s_axi_control.wdata;
                REG_BEATS_HI: beats_d[63:32] = s_axi_control.wdata;
                REG_GAP:      gap_d          = s_axi_control.wdata[15:0];
                REG_MODE:     mode_d         = s_axi_control.wdata[0];
                REG_SEED:     seed_d         = s_axi_control.wdata;
                default:      ;
            endcase
        end
    end

    // Read channel: address decode into a registered response
    always_comb begin
        rd_val = UNMAPPED_RDATA;
        case (s_axi_control.araddr)
            REG_CONTROL:  rd_val = control_q;
            REG_BEATS_LO: rd_val = beats_q[31:0];
            REG_BEATS_HI: rd_val = beats_q[63:32];
            REG_GAP:      rd_val = {16'h0000, gap_q};
            REG_MODE:     rd_val = {31'd0, mode_q};
            REG_SEED:     rd_val = seed_q;
            REG_SENT_LO:  rd_val = sent_i[31:0];
            REG_SENT_HI:  rd_val = sent_i[63:32];
            REG_STATUS:   rd_val = {30'd0, done_i, busy_i};
            default:      ;
        endcase
        rvalid_d = rvalid_q && !s_axi_control.rready;
        rdata_d  = rdata_q;
        if (s_axi_control.arvalid && !rvalid_q) begin
            rvalid_d = 1'b1;
            rdata_d  = rd_val;
        end
    end

    // Register state with asynchronous clear
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            awaddr_q  <= '0;
            control_q <= '0;
            beats_q   <= '0;
            gap_q     <= '0;
            mode_q    <= 1'b0;
            seed_q    <= '0;
            clear_q   <= 1'b0;
            bvalid_q  <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
        end else begin
            awaddr_q  <= awaddr_d;
            control_q <= control_d;
            beats_q   <= beats_d;
            gap_q     <= gap_d;
            mode_q    <= mode_d;
            seed_q    <= seed_d;
            clear_q   <= clear_d;
            bvalid_q  <= bvalid_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
        end
    end

endmodule

// File: rtl/axis_traffic_gen.sv
// AXI-Stream traffic generator. An AXI-Lite register file configures beat
// count, inter-beat gap, pattern mode and seed; the FSM here emits beats whose
// 32-bit lanes carry either the seed or seed + beat index.
module axis_traffic_gen
    import axis_traffic_gen_pkg::*;
#(
    parameter int DATA_BYTES = DATA_WIDTH,
    parameter int CTRL_BYTES = STORE_DATA_WIDTH
)(
    input  logic           ap_clk,
    input  logic           ap_rst_n,
    axil_ctrl_if.slave     s_axi_control,
    axis_stream_if.master  outstream
);

    localparam int LANE_W = CTRL_BYTES * 8;
    localparam int LANES  = DATA_BYTES / CTRL_BYTES;

    gen_state_e              state_q, state_d;
    logic [63:0]             sent_q, sent_d;
    logic [63:0]             index_q, index_d;
    logic [15:0]             gap_cnt_q, gap_cnt_d;
    logic                    clear_pend_q, clear_pend_d;
    logic [DATA_BYTES*8-1:0] tdata_q, tdata_d;
    logic                    load;

    logic [31:0] control;
    logic [63:0] beats;
    logic [15:0] gap;
    logic        mode;
    logic [31:0] seed;
    logic        clear;
    logic        hs;
    logic        start_ok;

    axis_gen_regs u_regs (
        .ap_clk        (ap_clk),
        .ap_rst_n      (ap_rst_n),
        .s_axi_control (s_axi_control),
        .sent_i        (sent_q),
        .busy_i        ((state_q == ST_SEND) || (state_q == ST_GAP)),
        .done_i        (state_q == ST_DONE),
        .control_o     (control),
        .beats_o       (beats),
        .gap_o         (gap),
        .mode_o        (mode),
        .seed_o        (seed),
        .clear_o       (clear)
    );

    assign outstream.tvalid = (state_q == ST_SEND);
    assign outstream.tdata  = tdata_q;

    assign hs       = (state_q == ST_SEND) && outstream.tready;
    assign start_ok = (control == CTRL_START) && ((beats == '0) || (sent_q < beats));

    // Next-state logic; a clear seen while a beat is pending waits for its handshake
    always_comb begin
        state_d      = state_q;
        sent_d       = sent_q;
        index_d      = index_q;
        gap_cnt_d    = gap_cnt_q;
        clear_pend_d = clear_pend_q;
        load         = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (clear) begin
                    sent_d  = '0;
                    index_d = '0;
                end
                if (start_ok) begin
                    state_d = ST_SEND;
                    load    = 1'b1;
                end
            end
            ST_SEND: begin
                if (clear) begin
                    clear_pend_d = 1'b1;
                end
                if (hs) begin
                    sent_d       = sent_q + 64'd1;
                    index_d      = index_q + 64'd1;
                    clear_pend_d = 1'b0;
                    if (clear || clear_pend_q) begin
                        sent_d  = '0;
                        index_d = '0;
                        state_d = ST_IDLE;
                    end else if ((beats != '0) && (sent_d == beats)) begin
                        state_d = ST_DONE;
                    end else if (control != CTRL_START) begin
                        state_d = ST_IDLE;
                    end else if (gap != '0) begin
                        state_d   = ST_GAP;
                        gap_cnt_d = gap - 16'd1;
                    end else begin
                        load = 1'b1;
                    end
                end
            end
            ST_GAP: begin
                if (clear) begin
                    sent_d  = '0;
                    index_d = '0;
                end
                if (gap_cnt_q == '0) begin
                    if (control == CTRL_START) begin
                        state_d = ST_SEND;
                        load    = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    gap_cnt_d = gap_cnt_q - 16'd1;
                end
            end
            ST_DONE: begin
                if (clear) begin
                    sent_d  = '0;
                    index_d = '0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Beat data is captured only when a new beat is launched, so it stays stable while stalled
    always_comb begin
        tdata_d = tdata_q;
        if (load) begin
            for (int l = 0; l < LANES; l++) begin
                tdata_d[l*LANE_W +: LANE_W] = lane_value(seed, mode, index_d[31:0]);
            end
        end
    end

    // FSM and datapath registers with asynchronous clear
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q      <= ST_IDLE;
            sent_q       <= '0;
            index_q      <= '0;
            gap_cnt_q    <= '0;
            clear_pend_q <= 1'b0;
            tdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            sent_q       <= sent_d;
            index_q      <= index_d;
            gap_cnt_q    <= gap_cnt_d;
            clear_pend_q <= clear_pend_d;
            tdata_q      <= tdata_d;
        end
    end

endmodule

// File: tb/tb_axis_traffic_gen.sv
// Bench for axis_traffic_gen: directed register/timing scenarios plus
// randomized runs; a scoreboard queue holds expected beats and a monitor
// compares every stream handshake against it.
module tb_axis_traffic_gen;

    localparam int DB = 8;
    localparam int TW = DB * 8;

    localparam logic [15:0] A_CONTROL  = 16'h0010;
    localparam logic [15:0] A_BEATS_LO = 16'h0014;
    localparam logic [15:0] A_BEATS_HI = 16'h0018;
    localparam logic [15:0] A_GAP      = 16'h001C;
    localparam logic [15:0] A_MODE     = 16'h0020;
    localparam logic [15:0] A_SEED     = 16'h0024;
    localparam logic [15:0] A_SENT_LO  = 16'h0028;
    localparam logic [15:0] A_SENT_HI  = 16'h002C;
    localparam logic [15:0] A_STATUS   = 16'h0030;

    logic ap_clk   = 1'b0;
    logic ap_rst_n = 1'b0;

    always #5 ap_clk = ~ap_clk;

    axil_ctrl_if ctrl ();
    axis_stream_if #(.DATA_BYTES(DB)) strm ();

    axis_traffic_gen #(.DATA_BYTES(DB), .CTRL_BYTES(4)) dut (
        .ap_clk        (ap_clk),
        .ap_rst_n      (ap_rst_n),
        .s_axi_control (ctrl),
        .outstream     (strm)
    );

    int              vectors;
    int              miscompares;
    int              hs_cnt;
    int              exp_gap;
    int              low_cnt;
    bit              gap_chk;
    bit              stab_en;
    bit              armed;
    bit              prev_stall;
    logic [TW-1:0]   prev_data;
    logic [TW-1:0]   exp_beat;
    logic [TW-1:0]   exp_q[$];
    logic [63:0]     m_index;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // Reference beat: every 32-bit lane holds seed (constant mode) or seed + index
    function automatic logic [TW-1:0] model_beat(input logic [31:0] seed, input bit mode,
                                                 input logic [63:0] idx);
        logic [TW-1:0] w;
        logic [31:0]   lane;
        lane = mode ? seed : (seed + idx[31:0]);
        for (int l = 0; l < DB / 4; l++) w[l*32 +: 32] = lane;
        return w;
    endfunction

    task automatic plan_run(input int n, input logic [31:0] seed, input bit mode);
        for (int k = 0; k < n; k++) begin
            exp_q.push_back(model_beat(seed, mode, m_index));
            m_index = m_index + 64'd1;
        end
    endtask

    task automatic step();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic axil_write(input logic [15:0] addr, input logic [31:0] data);
        ctrl.awvalid = 1'b1;
        ctrl.awaddr  = addr;
        ctrl.wvalid  = 1'b1;
        ctrl.wdata   = data;
        ctrl.wstrb   = 4'hf;
        step();
        ctrl.awvalid = 1'b0;
        ctrl.wvalid  = 1'b0;
        chk("bvalid_after_w", 64'(ctrl.bvalid), 64'd1);
        step();
    endtask

    task automatic axil_read(input logic [15:0] addr, output logic [31:0] data);
        int n;
        ctrl.arvalid = 1'b1;
        ctrl.araddr  = addr;
        step();
        ctrl.arvalid = 1'b0;
        n = 0;
        while (!ctrl.rvalid && n < 8) begin
            step();
            n++;
        end
        if (!ctrl.rvalid) chk("read_timeout", 64'd0, 64'd1);
        data = ctrl.rdata;
        step();
    endtask

    task automatic read_chk(input string name, input logic [15:0] addr, input logic [31:0] exp);
        logic [31:0] d;
        axil_read(addr, d);
        chk(name, 64'(d), 64'(exp));
    endtask

    task automatic cfg(input logic [63:0] beats, input logic [15:0] gap,
                       input logic [31:0] seed, input bit mode);
        axil_write(A_BEATS_LO, beats[31:0]);
        axil_write(A_BEATS_HI, beats[63:32]);
        axil_write(A_GAP, {16'h0000, gap});
        axil_write(A_SEED, seed);
        axil_write(A_MODE, {31'd0, mode});
    endtask

    task automatic wait_drain(input int budget, input bit rand_ready);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            if (rand_ready) strm.tready = 1'($urandom_range(0, 1));
            step();
            n++;
        end
        strm.tready = 1'b1;
        if (exp_q.size() != 0) chk("drain_timeout", 64'(exp_q.size()), 64'd0);
        step();
        step();
    endtask

    task automatic wait_tvalid();
        int n;
        n = 0;
        while (!strm.tvalid && n < 20) begin
            step();
            n++;
        end
        if (!strm.tvalid) chk("tvalid_timeout", 64'd0, 64'd1);
    endtask

    task automatic do_clear();
        axil_write(A_CONTROL, 32'd2);
        m_index = '0;
    endtask

    initial begin
        logic [31:0] seed;
        bit          mode;
        int          nb;
        int          g;
        int          n;
        int          base;
        bit          exp_v;

        vectors      = 0;
        miscompares  = 0;
        hs_cnt       = 0;
        exp_gap      = 0;
        low_cnt      = 0;
        gap_chk      = 1'b0;
        stab_en      = 1'b0;
        armed        = 1'b0;
        prev_stall   = 1'b0;
        prev_data    = '0;
        m_index      = '0;
        ctrl.awvalid = 1'b0;
        ctrl.awaddr  = '0;
        ctrl.wvalid  = 1'b0;
        ctrl.wdata   = '0;
        ctrl.wstrb   = '0;
        ctrl.bready  = 1'b1;
        ctrl.arvalid = 1'b0;
        ctrl.araddr  = '0;
        ctrl.rready  = 1'b1;
        strm.tready  = 1'b0;

        fork
            // Stream monitor: scoreboard pops, gap length and stall stability
            forever begin
                @(negedge ap_clk);
                if (ap_rst_n) begin
                    if (stab_en && prev_stall) begin
                        chk("stall_tvalid", 64'(strm.tvalid), 64'd1);
                        chk("stall_tdata", 64'(strm.tdata), 64'(prev_data));
                    end
                    if (gap_chk && armed) begin
                        if (strm.tvalid) begin
                            chk("gap_len", 64'(low_cnt), 64'(exp_gap));
                            armed = 1'b0;
                        end else begin
                            low_cnt++;
                        end
                    end
                    if (strm.tvalid && strm.tready) begin
                        hs_cnt++;
                        if (exp_q.size() == 0) begin
                            chk("unexpected_beat", 64'(strm.tdata), 64'd0 - 64'd1);
                        end else begin
                            exp_beat = exp_q.pop_front();
                            chk("beat_data", 64'(strm.tdata), 64'(exp_beat));
                            armed   = (exp_q.size() != 0);
                            low_cnt = 0;
                        end
                    end
                    prev_stall = strm.tvalid && !strm.tready;
                    prev_data  = strm.tdata;
                end else begin
                    prev_stall = 1'b0;
                end
            end
            begin
                #1000000;
                $display("FAIL watchdog: simulation did not finish");
                $fatal(1, "watchdog");
            end
        join_none

        // Reset state
        repeat (3) @(posedge ap_clk);
        #1;
        chk("reset_tvalid", 64'(strm.tvalid), 64'd0);
        chk("reset_tdata", 64'(strm.tdata), 64'd0);
        chk("reset_bvalid", 64'(ctrl.bvalid), 64'd0);
        chk("reset_rvalid", 64'(ctrl.rvalid), 64'd0);
        chk("reset_rdata", 64'(ctrl.rdata), 64'd0);
        ap_rst_n = 1'b1;
        step();
        read_chk("rst_control", A_CONTROL, 32'd0);
        read_chk("rst_beats", A_BEATS_LO, 32'd0);
        read_chk("rst_gap", A_GAP, 32'd0);
        read_chk("rst_seed", A_SEED, 32'd0);
        read_chk("rst_sent", A_SENT_LO, 32'd0);
        read_chk("rst_status", A_STATUS, 32'd0);
        read_chk("unmapped_rd", 16'h0040, 32'h1234_dead);

        // Four back-to-back beats, start issued as AW then W three cycles later
        strm.tready = 1'b1;
        gap_chk     = 1'b1;
        stab_en     = 1'b1;
        exp_gap     = 0;
        cfg(64'd4, 16'd0, 32'h100, 1'b0);
        plan_run(4, 32'h100, 1'b0);
        ctrl.awvalid = 1'b1;
        ctrl.awaddr  = A_CONTROL;
        step();
        ctrl.awvalid = 1'b0;
        ctrl.awaddr  = 16'h0000;
        step();
        step();
        chk("bvalid_before_w", 64'(ctrl.bvalid), 64'd0);
        ctrl.wvalid = 1'b1;
        ctrl.wdata  = 32'd1;
        step();
        ctrl.wvalid = 1'b0;
        chk("bvalid_n_plus_4", 64'(ctrl.bvalid), 64'd1);
        step();
        wait_drain(50, 1'b0);
        read_chk("control_rb", A_CONTROL, 32'd1);
        read_chk("sent4_lo", A_SENT_LO, 32'd4);
        read_chk("sent4_hi", A_SENT_HI, 32'd0);
        read_chk("status_done", A_STATUS, 32'd2);
        do_clear();
        read_chk("clear_sent", A_SENT_LO, 32'd0);
        read_chk("clear_status", A_STATUS, 32'd0);

        // Three beats separated by two idle cycles
        seed    = $urandom;
        exp_gap = 2;
        cfg(64'd3, 16'd2, seed, 1'b0);
        plan_run(3, seed, 1'b0);
        axil_write(A_CONTROL, 32'd1);
        wait_tvalid();
        for (int k = 0; k < 10; k++) begin
            exp_v = ((k % 3) == 0) && ((k / 3) < 3);
            chk("tvalid_pattern", 64'(strm.tvalid), 64'(exp_v));
            step();
        end
        wait_drain(50, 1'b0);
        read_chk("sent3", A_SENT_LO, 32'd3);
        do_clear();

        // Sink stalls the first beat for five cycles (constant-pattern mode)
        seed        = $urandom;
        strm.tready = 1'b0;
        exp_gap     = 0;
        cfg(64'd2, 16'd0, seed, 1'b1);
        plan_run(2, seed, 1'b1);
        axil_write(A_CONTROL, 32'd1);
        wait_tvalid();
        step();
        step();
        step();
        read_chk("sent_stalled", A_SENT_LO, 32'd0);
        strm.tready = 1'b1;
        wait_drain(50, 1'b0);
        read_chk("sent_after_stall", A_SENT_LO, 32'd2);
        do_clear();

        // Stop while a beat is pending: it completes, nothing follows
        gap_chk     = 1'b0;
        seed        = $urandom;
        strm.tready = 1'b0;
        cfg(64'd0, 16'd0, seed, 1'b0);
        plan_run(1, seed, 1'b0);
        axil_write(A_CONTROL, 32'd1);
        wait_tvalid();
        axil_write(A_CONTROL, 32'd0);
        strm.tready = 1'b1;
        repeat (10) step();
        chk("stop_tvalid", 64'(strm.tvalid), 64'd0);
        chk("stop_queue", 64'(exp_q.size()), 64'd0);
        read_chk("stop_status", A_STATUS, 32'd0);
        read_chk("stop_sent", A_SENT_LO, 32'd1);
        do_clear();

        // Randomized runs with a randomly stalling sink
        gap_chk = 1'b1;
        for (int it = 0; it < 6; it++) begin
            seed = (it == 0) ? 32'hffff_fffe : $urandom;
            mode = (it == 0) ? 1'b0 : 1'($urandom_range(0, 1));
            nb   = $urandom_range(1, 5);
            g    = $urandom_range(0, 3);
            if (it == 0) nb = 4;
            exp_gap = g;
            cfg(64'(nb), 16'(g), seed, mode);
            plan_run(nb, seed, mode);
            axil_write(A_CONTROL, 32'd1);
            wait_drain(300, 1'b1);
            read_chk("rand_status", A_STATUS, 32'd2);
            read_chk("rand_sent", A_SENT_LO, 32'(nb));
            do_clear();
        end

        // Asynchronous reset in the middle of a ten-beat run
        gap_chk     = 1'b0;
        stab_en     = 1'b0;
        seed        = $urandom;
        strm.tready = 1'b1;
        cfg(64'd10, 16'd0, seed, 1'b0);
        plan_run(10, seed, 1'b0);
        base = hs_cnt;
        axil_write(A_CONTROL, 32'd1);
        n = 0;
        while (hs_cnt < base + 3 && n < 50) begin
            step();
            n++;
        end
        strm.tready = 1'b0;
        step();
        chk("pre_reset_tvalid", 64'(strm.tvalid), 64'd1);
        ap_rst_n = 1'b0;
        #1;
        chk("async_tvalid_drop", 64'(strm.tvalid), 64'd0);
        exp_q.delete();
        armed   = 1'b0;
        m_index = '0;
        @(posedge ap_clk);
        @(posedge ap_clk);
        #1;
        ap_rst_n    = 1'b1;
        strm.tready = 1'b1;
        repeat (20) step();
        chk("post_reset_tvalid", 64'(strm.tvalid), 64'd0);
        read_chk("post_rst_control", A_CONTROL, 32'd0);
        read_chk("post_rst_beats", A_BEATS_LO, 32'd0);
        read_chk("post_rst_seed", A_SEED, 32'd0);
        read_chk("post_rst_sent", A_SENT_LO, 32'd0);
        read_chk("post_rst_status", A_STATUS, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
